// File: rtl/mem_controller_gen_if.sv
// CPU-side bus of mem_controller_gen: request/ready handshake, read-data
// return with a valid pulse, and a per-access fault pulse.
interface mem_controller_gen_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              fault;

  modport master (output req, we, addr, wdata, input ready, rdata, rvalid, fault);
  modport slave  (input req, we, addr, wdata, output ready, rdata, rvalid, fault);
endinterface

// File: rtl/mem_controller_gen.sv
// Dual-port word RAM controller: CPU port (req/ready/rvalid with fault
// reporting), read-only VGA port with 1-cycle latency, and a clear engine
// that fills the text region with CLEAR_VALUE after reset or on clr_req.
// Optional macro MEMCTRL_WPROT_EN adds instr_lock, which turns writes to the
// instruction region into faulting, dropped accesses.
module mem_controller_gen #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 15,
  parameter int TEXT_BASE   = 0,
  parameter int TEXT_SIZE   = 8192,
  parameter int GLYPH_BASE  = 8192,
  parameter int GLYPH_SIZE  = 1024,
  parameter int INSTR_BASE  = 9216,
  parameter int INSTR_SIZE  = 10240,
  parameter int CLEAR_VALUE = 0
) (
  input  logic              clk,
  input  logic              reset,
  mem_controller_gen_if.slave cpu,
  output logic              fault_sticky,
  output logic [ADDR_W-1:0] fault_addr,
  input  logic              fault_clr,
  input  logic              clr_req,
  output logic              clear_done,
`ifdef MEMCTRL_WPROT_EN
  input  logic              instr_lock,
`endif
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata
);

  localparam int DEPTH = 2**ADDR_W;

  // Region bounds carry one extra bit so base+size cannot wrap.
  localparam logic [ADDR_W:0] TEXT_LO  = (ADDR_W+1)'(TEXT_BASE);
  localparam logic [ADDR_W:0] TEXT_HI  = (ADDR_W+1)'(TEXT_BASE + TEXT_SIZE);
  localparam logic [ADDR_W:0] GLYPH_LO = (ADDR_W+1)'(GLYPH_BASE);
  localparam logic [ADDR_W:0] GLYPH_HI = (ADDR_W+1)'(GLYPH_BASE + GLYPH_SIZE);
  localparam logic [ADDR_W:0] INSTR_LO = (ADDR_W+1)'(INSTR_BASE);
  localparam logic [ADDR_W:0] INSTR_HI = (ADDR_W+1)'(INSTR_BASE + INSTR_SIZE);

  localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(TEXT_BASE);
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(TEXT_BASE + TEXT_SIZE - 1);
  localparam logic [DATA_W-1:0] CLR_WORD  = DATA_W'(CLEAR_VALUE);

  function automatic logic in_region(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W:0]   lo,
                                     input logic [ADDR_W:0]   hi);
    logic [ADDR_W:0] ax;
    ax = {1'b0, a};
    return (ax >= lo) && (ax < hi);
  endfunction

  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return in_region(a, TEXT_LO, TEXT_HI) | in_region(a, GLYPH_LO, GLYPH_HI) |
           in_region(a, INSTR_LO, INSTR_HI);
  endfunction

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready_q;
  logic              done_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc;
  logic              rd_acc;
  logic              cpu_mapped;
  logic              vga_mapped;
  logic              wr_blocked;
  logic              fault_now;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] cpu_word_p1;
  logic [DATA_W-1:0] vga_word_p1;
  logic              cpu_zero_p1;
  logic              vga_zero_p1;
  logic              vld_p1;
  logic              fault_p1;

  // Access decode and the single RAM write port (clear engine or CPU).
  always_comb begin
    acc        = cpu.req & ready_q;
    rd_acc     = acc & ~cpu.we;
    cpu_mapped = is_mapped(cpu.addr);
    vga_mapped = is_mapped(vga_addr);
`ifdef MEMCTRL_WPROT_EN
    wr_blocked = cpu.we & instr_lock & in_region(cpu.addr, INSTR_LO, INSTR_HI);
`else
    wr_blocked = 1'b0;
`endif
    fault_now  = acc & (~cpu_mapped | wr_blocked);
    wr_en      = 1'b0;
    wr_addr    = cpu.addr;
    wr_data    = cpu.wdata;
    if (state == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_data = CLR_WORD;
    end else if (acc && cpu.we && cpu_mapped && !wr_blocked) begin
      wr_en   = 1'b1;
    end
  end

  // RAM array: one write port, two read-first read ports (CPU and VGA).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_acc) cpu_word_p1 <= mem[cpu.addr];
    vga_word_p1 <= mem[vga_addr];
  end

  // Clear/run sequencer; ready and clear_done are registered with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_cnt <= CLR_FIRST;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state   <= S_RUN;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (clr_req) begin
            state   <= S_CLEAR;
            clr_cnt <= CLR_FIRST;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Response flags and fault capture; unmapped reads are forced to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      fault_p1     <= 1'b0;
      cpu_zero_p1  <= 1'b1;
      vga_zero_p1  <= 1'b1;
      fault_sticky <= 1'b0;
      fault_addr   <= '0;
    end else begin
      vld_p1      <= rd_acc;
      fault_p1    <= fault_now;
      vga_zero_p1 <= ~vga_mapped;
      if (rd_acc) cpu_zero_p1 <= ~cpu_mapped;
      if (fault_clr) begin
        fault_sticky <= 1'b0;
        fault_addr   <= '0;
      end else if (fault_now && !fault_sticky) begin
        fault_sticky <= 1'b1;
        fault_addr   <= cpu.addr;
      end
    end
  end

  assign cpu.ready  = ready_q;
  assign cpu.rdata  = cpu_zero_p1 ? '0 : cpu_word_p1;
  assign cpu.rvalid = vld_p1;
  assign cpu.fault  = fault_p1;
  assign clear_done = done_q;
  assign vga_rdata  = vga_zero_p1 ? '0 : vga_word_p1;

endmodule

// File: tb/tb_mem_controller_gen.sv
// Self-checking bench for mem_controller_gen: a behavioural model tracks RAM
// contents, clear progress and fault state; a negedge process compares the
// DUT against it every cycle, and directed checks pin literal values.
module tb_mem_controller_gen;

  localparam int TB_ = 0,    TS = 8192;
  localparam int GB  = 8192, GS = 1024;
  localparam int IB  = 9216, IS = 10240;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fault_clr = 1'b0;
  logic        clr_req = 1'b0;
  logic        fault_sticky;
  logic [14:0] fault_addr;
  logic        clear_done;
  logic [14:0] vga_addr = '0;
  logic [15:0] vga_rdata;
`ifdef MEMCTRL_WPROT_EN
  logic        instr_lock = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  mem_controller_gen_if #(.ADDR_W(15), .DATA_W(16)) cpu_bus ();

  mem_controller_gen dut (
    .clk          (clk),
    .reset        (reset),
    .cpu          (cpu_bus),
    .fault_sticky (fault_sticky),
    .fault_addr   (fault_addr),
    .fault_clr    (fault_clr),
    .clr_req      (clr_req),
    .clear_done   (clear_done),
`ifdef MEMCTRL_WPROT_EN
    .instr_lock   (instr_lock),
`endif
    .vga_addr     (vga_addr),
    .vga_rdata    (vga_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tb_mapped(input int a);
    return (a >= TB_ && a < TB_ + TS) || (a >= GB && a < GB + GS) || (a >= IB && a < IB + IS);
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] m_mem [0:32767];
  bit          m_known [0:32767];
  int          remaining = TS;
  bit          e_ready = 0, e_rvalid = 0, e_fault = 0, e_sticky = 0;
  logic [15:0] e_rdata = '0, e_vga = '0;
  logic [14:0] e_faddr = '0;
  bit          e_rdata_known = 1, e_vga_known = 1;
  int          m_a, m_v, m_idx;
  bit          m_acc, m_prot, m_bad;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining = TS;
      e_ready = 0; e_rvalid = 0; e_fault = 0; e_sticky = 0;
      e_faddr = '0; e_rdata = '0; e_rdata_known = 1; e_vga = '0; e_vga_known = 1;
    end else begin
      m_a   = int'(cpu_bus.addr);
      m_v   = int'(vga_addr);
      m_acc = cpu_bus.req && e_ready;
      m_prot = 0;
`ifdef MEMCTRL_WPROT_EN
      m_prot = instr_lock && cpu_bus.we && m_a >= IB && m_a < IB + IS;
`endif
      m_bad = m_acc && (!tb_mapped(m_a) || m_prot);
      e_vga       = tb_mapped(m_v) ? m_mem[m_v] : 16'h0;
      e_vga_known = tb_mapped(m_v) ? m_known[m_v] : 1'b1;
      e_rvalid = m_acc && !cpu_bus.we;
      if (e_rvalid) begin
        e_rdata       = tb_mapped(m_a) ? m_mem[m_a] : 16'h0;
        e_rdata_known = tb_mapped(m_a) ? m_known[m_a] : 1'b1;
      end
      e_fault = m_bad;
      if (fault_clr) begin
        e_sticky = 0; e_faddr = '0;
      end else if (m_bad && !e_sticky) begin
        e_sticky = 1; e_faddr = cpu_bus.addr;
      end
      if (remaining > 0) begin
        m_idx = TB_ + TS - remaining;
        m_mem[m_idx] = 16'h0;
        m_known[m_idx] = 1;
        remaining--;
      end else if (m_acc && cpu_bus.we && !m_bad) begin
        m_mem[m_a] = cpu_bus.wdata;
        m_known[m_a] = 1;
      end
      if (e_ready && clr_req) remaining = TS;
      e_ready = (remaining == 0);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_ready",      cpu_bus.ready,  e_ready);
      check("m_clear_done", clear_done,     e_ready);
      check("m_rvalid",     cpu_bus.rvalid, e_rvalid);
      check("m_fault",      cpu_bus.fault,  e_fault);
      check("m_sticky",     fault_sticky,   e_sticky);
      check("m_fault_addr", fault_addr,     e_faddr);
      if (e_rdata_known) check("m_rdata", cpu_bus.rdata, e_rdata);
      if (e_vga_known)   check("m_vga",   vga_rdata,     e_vga);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit req, input bit we, input int addr, input int wdata);
    cpu_bus.req   = req;
    cpu_bus.we    = we;
    cpu_bus.addr  = 15'(addr);
    cpu_bus.wdata = 16'(wdata);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0);
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (!clear_done && n < 9000) begin
      step();
      n++;
    end
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 63));
      1:       return 'h2000 + int'($urandom_range(0, 63));
      2:       return 'h2400 + int'($urandom_range(0, 63));
      default: return 'h4C00 + int'($urandom_range(0, 1023));
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int clr_used;
    idle();
    step();
    chk_on = 1;
    step();
    step();
    check("rst_ready",      cpu_bus.ready,  0);
    check("rst_clear_done", clear_done,     0);
    check("rst_rvalid",     cpu_bus.rvalid, 0);
    check("rst_fault",      cpu_bus.fault,  0);
    check("rst_sticky",     fault_sticky,   0);
    check("rst_fault_addr", fault_addr,     0);
    check("rst_rdata",      cpu_bus.rdata,  0);
    check("rst_vga",        vga_rdata,      0);

    reset = 0;
    wait_clear(n);
    check("clear_len", n, 8192);
    check("run_ready", cpu_bus.ready, 1);

    drive(1, 0, 0, 0); step(); idle();
    check("rd0_vld", cpu_bus.rvalid, 1);
    check("rd0_data", cpu_bus.rdata, 16'h0000);
    drive(1, 0, 8191, 0); step(); idle();
    check("rd8191_vld", cpu_bus.rvalid, 1);
    check("rd8191_data", cpu_bus.rdata, 16'h0000);

    drive(1, 1, 'h2005, 'hBEEF); step();
    drive(1, 0, 'h2005, 0); step(); idle();
    check("beef_vld", cpu_bus.rvalid, 1);
    check("beef_data", cpu_bus.rdata, 16'hBEEF);
    step();
    check("beef_vld_pulse", cpu_bus.rvalid, 0);
    check("beef_hold", cpu_bus.rdata, 16'hBEEF);

    drive(1, 0, 'h4C00, 0); step(); idle();
    check("unm_vld", cpu_bus.rvalid, 1);
    check("unm_data", cpu_bus.rdata, 0);
    check("unm_fault", cpu_bus.fault, 1);
    check("unm_sticky", fault_sticky, 1);
    check("unm_faddr", fault_addr, 'h4C00);
    drive(1, 1, 'h7FFF, 'h1111); step(); idle();
    check("unm2_fault", cpu_bus.fault, 1);
    check("unm2_faddr", fault_addr, 'h4C00);
    fault_clr = 1; step(); fault_clr = 0;
    check("fclr_sticky", fault_sticky, 0);
    check("fclr_faddr", fault_addr, 0);
    check("fclr_fault", cpu_bus.fault, 0);
    drive(1, 0, 'h5000, 0); fault_clr = 1; step(); idle(); fault_clr = 0;
    check("fclr_pri_fault", cpu_bus.fault, 1);
    check("fclr_pri_sticky", fault_sticky, 0);
    step();
    check("fclr_pri_lost", fault_sticky, 0);

    vga_addr = 'h0010;
    drive(1, 1, 'h0010, 'h1234); step(); idle();
    check("vga_old", vga_rdata, 16'h0000);
    step();
    check("vga_new", vga_rdata, 16'h1234);

`ifdef MEMCTRL_WPROT_EN
    instr_lock = 0;
    drive(1, 1, 'h2400, 'h5555); step();
    instr_lock = 1;
    drive(1, 1, 'h2400, 'hAAAA); step(); idle();
    check("wp_fault", cpu_bus.fault, 1);
    drive(1, 0, 'h2400, 0); step(); idle();
    check("wp_old", cpu_bus.rdata, 16'h5555);
    instr_lock = 0;
    drive(1, 1, 'h2400, 'hAAAA); step(); idle();
    check("wp_ok_fault", cpu_bus.fault, 0);
    drive(1, 0, 'h2400, 0); step(); idle();
    check("wp_new", cpu_bus.rdata, 16'hAAAA);
    step();
`endif

    clr_req = 1; step(); clr_req = 0;
    repeat (100) step();
    check("mid_clear_ready", cpu_bus.ready, 0);
    reset = 1;
    #2;
    check("arst_ready", cpu_bus.ready, 0);
    check("arst_done", clear_done, 0);
    step(); step();
    reset = 0;
    wait_clear(n);
    check("reclear_len", n, 8192);

    drive(1, 0, 'h2005, 0); clr_req = 1; step(); idle(); clr_req = 0;
    check("clrrd_vld", cpu_bus.rvalid, 1);
    check("clrrd_data", cpu_bus.rdata, 16'hBEEF);
    check("clrrd_ready", cpu_bus.ready, 0);
    wait_clear(n);
    check("clrreq_len", n, 8192);

    clr_used = 0;
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pick_addr(), int'($urandom));
      vga_addr  = 15'(pick_addr());
      fault_clr = ($urandom_range(0, 15) == 0);
      clr_req   = (clr_used == 0) && ($urandom_range(0, 499) == 0);
      if (clr_req) clr_used = 1;
`ifdef MEMCTRL_WPROT_EN
      instr_lock = $urandom_range(0, 1) == 1;
`endif
      step();
    end
    idle(); fault_clr = 0; clr_req = 0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
